// File: rtl/boot_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package boot_pkg;

  localparam int LEN_WIDTH  = 16;
  localparam int BYTE_WIDTH = 8;
  localparam int INST_WIDTH = 32;

  typedef enum logic [2:0] {
    LEN_LO,
    LEN_HI,
    PAYLOAD,
    CHECK,
    DONE,
    ERROR
  } boot_state_e;

endpackage

// File: rtl/boot_word_packer.sv
// Packs a byte stream little-endian into 32-bit words; word_valid_o pulses
// one cycle after the 4th byte of each word is accepted.
module boot_word_packer
  import boot_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  byte_valid_i,
  input  logic [BYTE_WIDTH-1:0] byte_i,
  output logic                  last_byte_o,
  output logic                  word_valid_o,
  output logic [INST_WIDTH-1:0] word_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [INST_WIDTH-1:0] word_q, word_d;
  logic                  word_valid_q, word_valid_d;

  // Shifting in from the top leaves the first byte of a word in bits [7:0].
  always_comb begin
    cnt_d        = cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (byte_valid_i) begin
      cnt_d        = cnt_q + 2'd1;
      word_d       = {byte_i, word_q[INST_WIDTH-1:BYTE_WIDTH]};
      word_valid_d = (cnt_q == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= 2'd0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign last_byte_o  = (cnt_q == 2'd3);
  assign word_valid_o = word_valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction
// memory and holds the CPU in reset until the image is verified.
//
//   state   | meaning
//   LEN_LO  | waiting for word count, low byte
//   LEN_HI  | waiting for word count, high byte; range check
//   PAYLOAD | packing image bytes into words and writing them
//   CHECK   | waiting for checksum byte
//   DONE    | image verified, CPU released (terminal)
//   ERROR   | overflow or checksum mismatch, CPU held (terminal)
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [BYTE_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [INST_WIDTH-1:0] imem_wdata,
  output logic                  cpu_rst_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam logic [LEN_WIDTH:0] CAPACITY = (LEN_WIDTH+1)'(1) << ADDR_WIDTH;

  boot_state_e           state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BYTE_WIDTH-1:0] csum_q, csum_d;
  logic [LEN_WIDTH-1:0]  n_full;
  logic                  xfer;
  logic                  pk_valid;
  logic                  last_byte;
  logic                  word_valid;
  logic [INST_WIDTH-1:0] word;

  assign in_ready = !rst && (state_q inside {LEN_LO, LEN_HI, PAYLOAD, CHECK});
  assign xfer     = in_valid && in_ready;

  boot_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data),
    .last_byte_o  (last_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    csum_d   = csum_q;
    pk_valid = 1'b0;
    n_full   = {in_data, len_q[BYTE_WIDTH-1:0]};

    // The last word's write lands after the move to CHECK, so the index
    // stops at N-1 instead of wrapping on a full-capacity image.
    if (word_valid && state_q == PAYLOAD) addr_d = addr_q + ADDR_WIDTH'(1);

    unique case (state_q)
      LEN_LO: begin
        if (xfer) begin
          len_d   = {len_q[LEN_WIDTH-1:BYTE_WIDTH], in_data};
          state_d = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d = n_full;
          if ({1'b0, n_full} > CAPACITY) state_d = ERROR;
          else if (n_full == '0)         state_d = CHECK;
          else                           state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (xfer) begin
          pk_valid = 1'b1;
          csum_d   = csum_q ^ in_data;
          if (last_byte && (LEN_WIDTH'(addr_q) == len_q - LEN_WIDTH'(1)))
            state_d = CHECK;
        end
      end
      CHECK: begin
        if (xfer) state_d = (in_data == csum_q) ? DONE : ERROR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LEN_LO;
      len_q   <= '0;
      addr_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      csum_q  <= csum_d;
    end
  end

  assign imem_we      = word_valid && !rst;
  assign imem_addr    = addr_q;
  assign imem_wdata   = word;
  assign load_done    = (state_q == DONE);
  assign load_err     = (state_q == ERROR);
  assign cpu_rst_hold = (state_q != DONE);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: stream-level reference model checked every
// cycle, plus literal expectations at the end of each directed load.
module tb_imem_boot_loader;

  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst_hold;
  logic          load_done;
  logic          load_err;

  imem_boot_loader #(.ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst_hold (cpu_rst_hold),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: p = bytes accepted since reset, mbytes = those bytes.
  logic [7:0]  mbytes [0:2047];
  int          p = 0;
  int          m_len = 0;
  bit          m_ok = 1'b0;
  bit          m_we = 1'b0;
  int          m_addr = 0;
  logic [31:0] m_wdata = '0;
  bit          m_rst_seen = 1'b0;
  bit          m_started = 1'b0;

  function automatic bit m_term();
    if (p < 2) return 1'b0;
    if (m_len > CAP) return 1'b1;
    return p >= 3 + 4 * m_len;
  endfunction

  function automatic bit m_done();
    return (p >= 2) && (m_len <= CAP) && (p == 3 + 4 * m_len) && m_ok;
  endfunction

  always @(posedge clk) begin
    logic [7:0] cs;
    m_started  = 1'b1;
    m_we       = 1'b0;
    m_rst_seen = rst;
    if (rst) begin
      p     = 0;
      m_len = 0;
      m_ok  = 1'b0;
    end else if (in_valid && !m_term()) begin
      mbytes[p] = in_data;
      if (p == 1) begin
        m_len = int'(mbytes[0]) + 256 * int'(mbytes[1]);
      end else if (p >= 2 && p < 2 + 4 * m_len) begin
        if ((p - 2) % 4 == 3) begin
          m_we    = 1'b1;
          m_addr  = (p - 2) / 4;
          m_wdata = {mbytes[p], mbytes[p-1], mbytes[p-2], mbytes[p-3]};
        end
      end else if (p >= 2) begin
        cs = 8'h00;
        for (int i = 2; i < p; i++) cs ^= mbytes[i];
        m_ok = (in_data == cs);
      end
      p++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write log and literal end-of-load expectations (pin_id set by stimulus).
  logic [AW-1:0] log_a [0:1023];
  logic [31:0]   log_d [0:1023];
  int            wr_cnt = 0;
  int            base = 0;
  int            pin_id = 0;
  logic [31:0]   exp_last = '0;

  always @(negedge clk) begin
    if (m_started) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, !rst && !m_term()});
      check("imem_we", {31'b0, imem_we}, {31'b0, m_we && !rst});
      check("load_done", {31'b0, load_done}, {31'b0, m_done()});
      check("load_err", {31'b0, load_err}, {31'b0, m_term() && !m_done()});
      check("cpu_rst_hold", {31'b0, cpu_rst_hold}, {31'b0, !m_done()});
      if (m_rst_seen) begin
        check("rst_imem_addr", 32'(imem_addr), 32'h0);
        check("rst_imem_wdata", imem_wdata, 32'h0);
      end
      if (imem_we && m_we) begin
        check("imem_addr", 32'(imem_addr), 32'(m_addr));
        check("imem_wdata", imem_wdata, m_wdata);
      end
      if (imem_we) begin
        log_a[wr_cnt] = imem_addr;
        log_d[wr_cnt] = imem_wdata;
        wr_cnt++;
      end
      case (pin_id)
        1: begin
          check("t1_writes", 32'(wr_cnt - base), 32'd2);
          check("t1_addr0", 32'(log_a[base]), 32'd0);
          check("t1_data0", log_d[base], 32'h407281B3);
          check("t1_addr1", 32'(log_a[base+1]), 32'd1);
          check("t1_data1", log_d[base+1], 32'h007372B3);
          check("t1_done", {31'b0, load_done}, 32'd1);
          check("t1_err", {31'b0, load_err}, 32'd0);
          check("t1_hold", {31'b0, cpu_rst_hold}, 32'd0);
          check("t1_ready", {31'b0, in_ready}, 32'd0);
        end
        2: begin
          check("t2_writes", 32'(wr_cnt - base), 32'd2);
          check("t2_data0", log_d[base], 32'h407281B3);
          check("t2_data1", log_d[base+1], 32'h007372B3);
          check("t2_err", {31'b0, load_err}, 32'd1);
          check("t2_done", {31'b0, load_done}, 32'd0);
          check("t2_hold", {31'b0, cpu_rst_hold}, 32'd1);
          check("t2_ready", {31'b0, in_ready}, 32'd0);
        end
        3: begin
          check("t3_writes", 32'(wr_cnt - base), 32'd0);
          check("t3_done", {31'b0, load_done}, 32'd1);
        end
        4: begin
          check("t4_writes", 32'(wr_cnt - base), 32'd0);
          check("t4_err", {31'b0, load_err}, 32'd1);
          check("t4_hold", {31'b0, cpu_rst_hold}, 32'd1);
        end
        6: begin
          check("t6_pre_writes", 32'(wr_cnt - base), 32'd1);
          check("t6_pre_data0", log_d[base], 32'h407281B3);
          check("t6_pre_done", {31'b0, load_done}, 32'd0);
        end
        7: begin
          check("t7_writes", 32'(wr_cnt - base), 32'd256);
          check("t7_first_addr", 32'(log_a[base]), 32'd0);
          check("t7_last_addr", 32'(log_a[wr_cnt-1]), 32'd255);
          check("t7_last_data", log_d[wr_cnt-1], exp_last);
          check("t7_done", {31'b0, load_done}, 32'd1);
        end
        default: ;
      endcase
    end
  end

  logic [7:0] t1 [0:10] = '{8'h02, 8'h00, 8'hB3, 8'h81, 8'h72, 8'h40,
                            8'hB3, 8'h72, 8'h73, 8'h00, 8'hB2};

  // All stimulus tasks start and end #1 after a rising edge.
  task automatic send(input logic [7:0] b, input int gmax);
    int gaps;
    gaps = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    repeat (gaps) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic pin(input int id);
    pin_id = id;
    @(negedge clk); #1;
    pin_id = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] cs;
    logic [7:0] b;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: clean two-word image
    base = wr_cnt;
    for (int i = 0; i < 11; i++) send(t1[i], 0);
    pin(1);

    // 2: bad checksum, then trailing bytes
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 10; i++) send(t1[i], 0);
    send(8'hB3, 0);
    for (int i = 0; i < 5; i++) send(8'h11 * 8'(i + 1), 0);
    pin(2);

    // 3: empty image
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 3; i++) send(8'h00, 0);
    pin(3);

    // 4: N = 257 overflows a 256-word memory
    do_reset();
    base = wr_cnt;
    send(8'h01, 0);
    send(8'h01, 0);
    for (int i = 0; i < 4; i++) send(8'hA5, 0);
    pin(4);

    // 5: clean image with random stalls
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 11; i++) send(t1[i], 3);
    pin(1);

    // 6: reset mid-load, then full reload
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 7; i++) send(t1[i], 0);
    pin(6);
    do_reset();
    base = wr_cnt;
    for (int i = 0; i < 11; i++) send(t1[i], 0);
    pin(1);

    // 7: N = 256 fills memory exactly
    do_reset();
    base = wr_cnt;
    send(8'h00, 0);
    send(8'h01, 0);
    cs = 8'h00;
    for (int j = 0; j < 1024; j++) begin
      b  = 8'((j * 7 + 3) & 255);
      cs ^= b;
      if (j >= 1020) exp_last[(j-1020)*8 +: 8] = b;
      send(b, 0);
    end
    send(cs, 0);
    pin(7);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name:
imem_boot_loader

Overview:
- Sits upstream of RV32I_Top.
- Receives a byte stream (program image) over a valid/ready handshake.
- Packs bytes little-endian into 32-bit instructions and writes them sequentially into the instruction memory write port, starting at word 0.
- Holds the CPU in reset until the image is loaded and checksum-verified.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; capacity = 2**ADDR_WIDTH words.

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  in_data holds a valid byte
in_data  input  8  stream byte
in_ready  output  1  loader can accept a byte; transfer when in_valid && in_ready
imem_we  output  1  one-cycle instruction-memory write strobe
imem_addr  output  ADDR_WIDTH  word address for the write
imem_wdata  output  32  instruction word to write
cpu_rst_hold  output  1  active-high reset request to RV32I_Top
load_done  output  1  image loaded and verified (sticky)
load_err  output  1  length overflow or checksum mismatch (sticky)

Behaviour:
- Reset is synchronous on clk, active-high. While rst=1 (registered values):
  - in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0
  - cpu_rst_hold=1, load_done=0, load_err=0
  - state=LEN_LO, byte/word counters=0, checksum=0
- Stream format:
  - Length N: 16-bit word count, low byte first.
  - Payload: N*4 bytes, each word little-endian (first byte -> wdata[7:0]).
  - Checksum: 1 byte, the XOR of all payload bytes. Length bytes are excluded.
- in_ready=1 in LEN_LO, LEN_HI, PAYLOAD and CHECK (when rst=0); 0 in DONE and ERROR. in_ready is a decode of state only, with no combinational path from in_valid.
- FSM:
  - LEN_LO: on transfer, latch N[7:0] and go to LEN_HI.
  - LEN_HI: on transfer, latch N[15:8], then:
    - if N > 2**ADDR_WIDTH, go to ERROR;
    - else if N == 0, go to CHECK;
    - else go to PAYLOAD.
  - PAYLOAD:
    - Each transfer shifts the byte into the packer and XORs it into the checksum.
    - A 2-bit byte counter wraps after the 4th byte.
    - On the 4th byte's transfer cycle T:
      - in cycle T+1: imem_we=1, imem_wdata=packed word, imem_addr=current word index;
      - the word index then increments.
    - After word N-1 is completed, go to CHECK (counter wraps to 0).
  - CHECK: on transfer, go to DONE if in_data == checksum, else go to ERROR.
  - DONE:
    - load_done=1 and cpu_rst_hold=0 from the cycle after the checksum transfer.
    - Terminal until rst. in_valid is ignored.
  - ERROR:
    - load_err=1 from the cycle after the offending transfer; cpu_rst_hold stays 1.
    - Terminal until rst.
- imem_we is never high for 2 consecutive cycles; at most one write per 4 transfers.
- in_valid gaps (stalls) at any point: state, counters and checksum hold.
- Boundaries:
  - N == 2**ADDR_WIDTH fills memory exactly; the last write is to address all-ones.
  - The word index never wraps in a legal load.
  - load_done and load_err are never both 1.
- Reset mid-load: everything returns to reset values next cycle. Words already written remain in memory and are overwritten by the next load. No write occurs in the reset cycle, even if a 4th byte is presented.

Decomposition:
- Shared package (boot_pkg):
  - FSM state encoding: LEN_LO, LEN_HI, PAYLOAD, CHECK, DONE, ERROR
  - LEN_WIDTH=16, BYTE_WIDTH=8, INST_WIDTH=32
- One sub-module, boot_word_packer:
  - 2-bit byte counter plus 32-bit little-endian shift/assemble register.
  - Outputs word_valid one cycle after the 4th byte, with the packed word.
  - Top keeps the FSM, length/word counters, checksum and the output registers.

Test Plan:
1. Stream 02 00 B3 81 72 40 B3 72 73 00 B2, in_valid held high.
   - imem_we pulses twice: addr0=0x407281B3, addr1=0x007372B3.
   - load_done=1 and cpu_rst_hold=0 one cycle after the B2 transfer; in_ready=0 afterward.
2. Same stream with last byte B3.
   - No change to the two writes.
   - load_err=1, load_done=0, cpu_rst_hold=1, in_ready=0.
   - Extra bytes afterward cause no writes.
3. Stream 00 00 00.
   - No imem_we; load_done=1 after the 3rd transfer.
4. ADDR_WIDTH=8, stream 01 01.
   - load_err=1 one cycle after the second byte; no imem_we.
   - Further in_valid is ignored.
5. Test 1 stream with random 0-3 cycle in_valid gaps.
   - Identical write sequence and final status.
   - Each imem_we is exactly 1 cycle.
6. Send 02 00 B3 81 72 40 B3, then assert rst for 1 cycle mid-stream, then send the full test-1 stream.
   - First write (addr0) occurs before reset.
   - After reset: outputs return to reset values, then the full load succeeds with writes to addr0/addr1.
   - load_done=1.
